// File: rtl/boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   loader_state_t : loader FSM states
//   BYTES_PER_WORD : payload bytes packed into one instruction word
//   DEFAULT_MAGIC  : default frame start byte
package boot_loader_pkg;

  typedef enum logic [2:0] {
    BOOT,
    WAIT_MAGIC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] DEFAULT_MAGIC  = 8'hA5;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// byte_word_packer: assembles little-endian 32-bit words from a byte stream.
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   byte_valid   : byte_data is consumed this cycle
//   byte_data    : incoming byte, placed in lane 'lane'
//   clear        : restart assembly at lane 0 (takes priority over byte_valid)
//   word         : assembly register; complete while word_valid is high
//   word_valid   : one-cycle pulse, the cycle after the 4th byte is consumed
//   lane         : lane the next byte will occupy
module byte_word_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  lane
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane       <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= 2'd0;
        word <= 32'd0;
      end else if (byte_valid) begin
        word[{lane, 3'b000} +: 8] <= byte_data;
        lane                      <= lane + 2'd1;
        // The 4th byte lands on this edge, so the word is whole during the pulse.
        word_valid                <= (lane == 2'(BYTES_PER_WORD - 1));
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte stream (MAGIC, LEN lo, LEN hi,
// LEN*4 payload bytes, XOR checksum), writes the payload into instruction
// memory and holds the core in reset until a verified image is loaded.
// Ports:
//   clk, reset_n          : clock and synchronous active-low reset
//   rx_valid, rx_data     : incoming byte stream
//   rx_ready              : byte accepted when rx_valid & rx_ready
//   start                 : reload request, honoured in RUN and ERROR
//   imem_we/addr/wdata    : instruction memory write port
//   cpu_reset_n           : core reset, released only in RUN
//   busy, done, error     : load in progress / image running / load failed
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  loader_state_t         state, next_state;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [15:0]           len_rx;
  logic [ADDR_WIDTH:0]   word_addr;
  logic [7:0]            chk;
  logic                  accept;
  logic                  len_bad;
  logic                  last_word;
  logic [1:0]            byte_cnt;
  logic [31:0]           word;
  logic                  word_valid;
  logic                  busy_d, done_d, error_d, cpu_reset_n_d;

  assign accept    = rx_valid & rx_ready;
  assign len_rx    = {rx_data, len_lo};
  // Upper bound is inclusive: a full 2^ADDR_WIDTH-word image is legal.
  assign len_bad   = (len_rx == 16'd0) ||
                     (32'(len_rx) > (32'd1 << ADDR_WIDTH));
  // word_addr still indexes the word being assembled when its 4th byte arrives.
  assign last_word = (32'(word_addr) + 32'd1) == 32'(len);

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      WAIT_MAGIC, LEN_LO, LEN_HI, DATA, CHECK: rx_ready = 1'b1;
      default:                                 rx_ready = 1'b0;
    endcase
  end

  byte_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_valid (accept && (state == DATA)),
    .byte_data  (rx_data),
    .clear      (accept && (state == LEN_HI)),
    .word       (word),
    .word_valid (word_valid),
    .lane       (byte_cnt)
  );

  assign imem_we    = word_valid;
  assign imem_addr  = word_addr[ADDR_WIDTH-1:0];
  assign imem_wdata = word;

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BOOT;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      state       <= next_state;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      cpu_reset_n <= cpu_reset_n_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      BOOT:       next_state = WAIT_MAGIC;
      WAIT_MAGIC: if (accept && (rx_data == MAGIC)) next_state = LEN_LO;
      LEN_LO:     if (accept) next_state = LEN_HI;
      LEN_HI:     if (accept) next_state = len_bad ? ERROR : DATA;
      DATA:       if (accept && (byte_cnt == 2'(BYTES_PER_WORD - 1)) && last_word)
                    next_state = CHECK;
      CHECK:      if (accept) next_state = (rx_data == chk) ? RUN : ERROR;
      RUN, ERROR: if (start) next_state = WAIT_MAGIC;
      default:    next_state = BOOT;
    endcase
  end

  // Status outputs are decoded from next_state so they align with the state.
  always_comb begin
    busy_d        = 1'b0;
    done_d        = 1'b0;
    error_d       = 1'b0;
    cpu_reset_n_d = 1'b0;
    case (next_state)
      WAIT_MAGIC, LEN_LO, LEN_HI, DATA, CHECK: busy_d = 1'b1;
      RUN: begin
        done_d        = 1'b1;
        cpu_reset_n_d = 1'b1;
      end
      ERROR:   error_d = 1'b1;
      default: ;
    endcase
  end

  // Length, address and checksum datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_lo    <= 8'd0;
      len       <= 16'd0;
      word_addr <= '0;
      chk       <= 8'd0;
    end else begin
      if (accept && (state == LEN_LO)) len_lo <= rx_data;
      if (accept && (state == LEN_HI)) begin
        len       <= len_rx;
        word_addr <= '0;
        chk       <= 8'd0;
      end else begin
        if (word_valid) word_addr <= word_addr + 1'b1;
        if (accept && (state == DATA)) chk <= chk ^ rx_data;
      end
    end
  end

endmodule
